mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port memory between the IF-stage fetch port and the MEM-stage data port.
// - Sits between the pipeline's instruction/data memory users and a unified memory.
// - Sequences each access as request -> grant -> response, one transaction outstanding.
// - Drives per-requester stall lines to the hazard unit.
// PARAMETERS
// - ADDR_W      32  byte-address width of all ports
// - DATA_W      32  data width; byte-enable width is DATA_W/8
// - MAX_STARVE  3   consecutive data-port wins (fetch pending) before fetch is forced; 1..15
// PORTS
// - clk        in   1           clock; all state updates on posedge
// - reset      in   1           synchronous, active-low reset (0 = reset)
// - if_req     in   1           fetch request; held until if_rvalid
// - if_addr    in   ADDR_W      fetch address
// - if_rdata   out  DATA_W      fetch data, valid with if_rvalid
// - if_rvalid  out  1           fetch complete (1 cycle pulse)
// - if_stall   out  1           fetch pending and not completing this cycle
// - d_req      in   1           data request; held until d_rvalid
// - d_we       in   1           1 = store, 0 = load
// - d_be       in   DATA_W/8    store byte enables
// - d_addr     in   ADDR_W      data address
// - d_wdata    in   DATA_W      store data
// - d_rdata    out  DATA_W      load data, valid with d_rvalid
// - d_rvalid   out  1           data access complete (load data or store ack), 1 cycle pulse
// - d_stall    out  1           data pending and not completing this cycle
// - m_req      out  1           memory request, held until m_gnt
// - m_we, m_be, m_addr, m_wdata  out  1/DATA_W/8/ADDR_W/DATA_W   registered request payload
// - m_gnt      in   1           memory accepted request this cycle
// - m_rvalid   in   1           memory response (read data or write ack)
// - m_rdata    in   DATA_W      memory read data
// BEHAVIOUR
// - FSM states: IDLE -> ISSUE -> RESP -> IDLE.
// - IDLE
//   - If any request is pending, arbitrate.
//   - Latch the winner's payload into the m_* registers and record the owner (IF or D).
//   - Go to ISSUE; m_req rises the next cycle.
// - Arbitration
//   - Data wins over fetch, except when starve_cnt == MAX_STARVE; then fetch wins.
//   - starve_cnt is 4 bits.
//   - starve_cnt +1 on a data win while if_req=1, saturating at MAX_STARVE.
//   - starve_cnt clears on any fetch win.
//   - starve_cnt holds when fetch is idle.
// - ISSUE: m_req=1 with stable payload until a cycle with m_gnt=1, then go to RESP.
// - RESP
//   - Wait for m_rvalid.
//   - On m_rvalid, the owner's rvalid=1 and its rdata=m_rdata (combinational pass-through).
//   - Go to IDLE.
// - m_rvalid is ignored outside RESP. An m_rvalid in the same cycle as m_gnt is not a response.
// - Latency
//   - Request is sampled in IDLE at cycle N; m_req is high at N+1.
//   - With m_gnt at N+1 and m_rvalid at N+2, rvalid is at N+2.
//   - Minimum 2 cycles; one IDLE bubble between transactions.
// - Stalls: x_stall = x_req & ~x_rvalid (combinational); asserted through the whole wait, including while the other port owns memory.
// - if_rdata and d_rdata are 0 when their rvalid=0.
// - Stores complete only on m_rvalid (write ack), never on m_gnt alone.
// - Simultaneous new requests on both ports in IDLE: exactly one wins. The loser stays stalled and is served next, unless a new data request out-arbitrates it (bounded by MAX_STARVE).
// - Reset (reset==0 at posedge)
//   - state=IDLE, starve_cnt=0, owner=IF.
//   - m_req=0; m_we/m_be/m_addr/m_wdata=0.
//   - rvalids=0.
//   - Any transaction in flight is abandoned; a late m_rvalid after reset is ignored (state IDLE).
// - Requester dropping req mid-transaction is illegal; the arbiter completes the transaction regardless, and the pulse is still emitted.
// CONFIGURATION
// - ARB_PERF_CNT_EN defined
//   - Adds output perf_conflict_cnt[31:0] and perf_busy_cnt[31:0].
//   - perf_conflict_cnt: +1 each cycle with if_req & d_req both high.
//   - perf_busy_cnt: +1 each cycle state != IDLE.
//   - Both counters reset to 0, wrap at 2^32, and are read-only.
// - ARB_PERF_CNT_EN undefined
//   - Ports and counters are absent.
//   - Functional behaviour is identical.
// TESTING
// - Single fetch: if_req=1, addr 0x100; mem gnt at once, rvalid 1 cycle later with 0xDEADBEEF.
//   -> if_rvalid at cycle 2, if_rdata=0xDEADBEEF, if_stall=1 for cycles 0-1.
// - Contention: if_req and d_req (load 0x200) rise together.
//   -> data served first, fetch second; if_stall high until its own rvalid; d_stall low after d_rvalid.
// - Starvation: d_req held continuously (back-to-back loads), if_req=1, MAX_STARVE=3.
//   -> 3 data grants, then 1 fetch grant, then starve_cnt=0.
// - Store with slow memory: d_we=1, be=4'b0011, wdata 0x1234; m_gnt delayed 3 cycles, m_rvalid 2 cycles later.
//   -> m_* payload stable throughout; d_rvalid only on m_rvalid; m_rvalid during IDLE ignored.
// - Reset mid-RESP: assert reset=0 for 1 cycle while waiting on m_rvalid.
//   -> m_req=0, rvalids=0, FSM IDLE; the following m_rvalid is not forwarded.
// - ARB_PERF_CNT_EN: 5 cycles with both reqs high.
//   -> perf_conflict_cnt increases by 5; undefined build compiles without the ports.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-port memory between the IF-stage fetch port and the
// MEM-stage data port. Each access runs request -> grant -> response, and
// only one transaction is outstanding at a time. Data normally wins a
// conflict; fetch is forced through after MAX_STARVE consecutive data wins
// taken while fetch was waiting.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   if_req/if_addr              fetch request (held until if_rvalid)
//   if_rdata/if_rvalid/if_stall fetch response and stall to hazard unit
//   d_req/d_we/d_be/d_addr/d_wdata  data request (held until d_rvalid)
//   d_rdata/d_rvalid/d_stall    data response / store ack, stall
//   m_req/m_we/m_be/m_addr/m_wdata  memory request, payload registered
//   m_gnt/m_rvalid/m_rdata      memory handshake and response
//
// Optional feature macro: ARB_PERF_CNT_EN adds perf_conflict_cnt and
// perf_busy_cnt (free-running 32-bit counters, wrap, reset to 0).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                d_stall,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_busy_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state, state_nx;
  logic       owner_d;      // 1: data port owns the memory, 0: fetch
  logic [3:0] starve_cnt;
  logic       any_req;
  logic       starved;
  logic       fetch_win;
  logic       resp;

  assign any_req   = if_req | d_req;
  assign starved   = (starve_cnt == 4'(MAX_STARVE));
  assign fetch_win = if_req & (~d_req | starved);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req)  state_nx = ISSUE;
      ISSUE:   if (m_gnt)    state_nx = RESP;
      RESP:    if (m_rvalid) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // A response is only meaningful in RESP; m_rvalid anywhere else
  // (including the grant cycle) is dropped here.
  always_comb begin
    resp      = (state == RESP) & m_rvalid;
    m_req     = (state == ISSUE);
    if_rvalid = resp & ~owner_d;
    d_rvalid  = resp &  owner_d;
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rdata   = d_rvalid  ? m_rdata : '0;
    if_stall  = if_req & ~if_rvalid;
    d_stall   = d_req  & ~d_rvalid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      owner_d    <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        if (fetch_win) begin
          owner_d    <= 1'b0;
          m_we       <= 1'b0;
          m_be       <= '1;
          m_addr     <= if_addr;
          m_wdata    <= '0;
          starve_cnt <= 4'd0;
        end else begin
          owner_d <= 1'b1;
          m_we    <= d_we;
          m_be    <= d_be;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          // Only wins taken over a waiting fetch count toward starvation.
          if (if_req && starve_cnt < 4'(MAX_STARVE))
            starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_conflict_cnt <= 32'd0;
      perf_busy_cnt     <= 32'd0;
    end else begin
      if (if_req && d_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (state != IDLE)   perf_busy_cnt     <= perf_busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata;
  logic        if_rvalid, if_stall, d_rvalid, d_stall;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_cnt, perf_busy_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_rvalid(if_rvalid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: transaction-level view of the arbiter plus a memory slave.
  bit          busy;            // a transaction is outstanding
  int          owner;           // 0 fetch, 1 data
  int          starve;          // data wins in a row over a waiting fetch
  logic        ew;
  logic [3:0]  ebe;
  logic [31:0] eaddr, ewd;
  int          wins[$];
  logic [31:0] mem [logic [31:0]];
  // memory slave
  int sst;                      // 0 idle, 1 waiting to grant, 2 accepted
  int gcnt, rcnt, gnt_lat, rsp_lat, spur_pct;
  bit rnd_lat;
  // requester agents
  bit if_auto, d_auto;
  int re_pct, start_pct;
  int cyc_n, last_if_rv, last_d_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3C3_0F0F;
  endfunction

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = 32'h1000 + ($urandom_range(0, 15) << 2);
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_addr  = 32'h2000 + ($urandom_range(0, 7) << 2);
    d_we    = 1'($urandom_range(0, 1));
    d_be    = 4'($urandom_range(1, 15));
    d_wdata = $urandom;
  endtask

  // One clock cycle: drive the memory side, check outputs, advance models.
  task automatic cyc();
    bit          real_rsp, exp_ifv, exp_dv, busy_old, ifr, dr, fw;
    logic [31:0] rsp_data, v;
    if (sst == 0 && m_req === 1'b1) begin
      sst  = 1;
      gcnt = rnd_lat ? $urandom_range(0, 3) : gnt_lat;
    end
    m_gnt    = (sst == 1 && gcnt == 0);
    real_rsp = (sst == 2 && rcnt == 0);
    m_rvalid = real_rsp;
    m_rdata  = $urandom;
    if (real_rsp && !ew) m_rdata = memrd(m_addr);
    if (!real_rsp && sst != 2 && $urandom_range(0, 99) < spur_pct) m_rvalid = 1'b1;
    rsp_data = m_rdata;
    #1;
    exp_ifv = real_rsp && owner == 0;
    exp_dv  = real_rsp && owner == 1;
    chk("m_req", m_req, busy && sst != 2);
    if (busy && sst != 2) begin
      chk("m_addr", m_addr, eaddr);
      chk("m_we", m_we, ew);
      if (owner == 1) begin
        chk("m_be", m_be, ebe);
        chk("m_wdata", m_wdata, ewd);
      end
    end
    chk("if_rvalid", if_rvalid, exp_ifv);
    chk("d_rvalid", d_rvalid, exp_dv);
    chk("if_rdata", if_rdata, exp_ifv ? memrd(if_addr) : 32'h0);
    chk("d_rdata", d_rdata, exp_dv ? (d_we ? rsp_data : memrd(d_addr)) : 32'h0);
    chk("if_stall", if_stall, if_req && !exp_ifv);
    chk("d_stall", d_stall, d_req && !exp_dv);
    busy_old = busy;
    ifr = if_req;
    dr  = d_req;
    @(posedge clk);
    #1;
    if (real_rsp) begin
      busy = 0;
      if (owner == 1 && d_we) begin
        v = memrd(d_addr);
        for (int b = 0; b < 4; b++) if (d_be[b]) v[8*b +: 8] = d_wdata[8*b +: 8];
        mem[d_addr] = v;
      end
    end
    if (!busy_old && (ifr || dr)) begin
      fw = ifr && (!dr || starve == MAXS);
      if (fw) begin
        owner = 0; starve = 0; ew = 1'b0; eaddr = if_addr;
      end else begin
        owner = 1;
        if (ifr && starve < MAXS) starve++;
        ew = d_we; ebe = d_be; eaddr = d_addr; ewd = d_wdata;
      end
      busy = 1;
      wins.push_back(owner);
    end
    if (sst == 1) begin
      if (m_gnt) begin
        sst  = 2;
        rcnt = (rnd_lat ? $urandom_range(1, 3) : rsp_lat) - 1;
      end else gcnt--;
    end else if (sst == 2) begin
      if (real_rsp) sst = 0; else rcnt--;
    end
    m_gnt = 1'b0; m_rvalid = 1'b0;
    if (exp_ifv) begin
      last_if_rv = cyc_n;
      if (if_auto && $urandom_range(0, 99) < re_pct) new_if(); else if_req = 1'b0;
    end else if (if_auto && !if_req && $urandom_range(0, 99) < start_pct) new_if();
    if (exp_dv) begin
      last_d_rv = cyc_n;
      if (d_auto && $urandom_range(0, 99) < re_pct) new_d(); else d_req = 1'b0;
    end else if (d_auto && !d_req && $urandom_range(0, 99) < start_pct) new_d();
    cyc_n++;
  endtask

  task automatic drain();
    if_auto = 0; d_auto = 0;
    for (int k = 0; k < 300 && (busy || if_req || d_req); k++) cyc();
    chk("drain_timeout", {31'd0, busy || if_req || d_req}, 32'd0);
  endtask

  initial begin
    int start, k;
    logic [31:0] c0, b0;
    reset = 1'b0; if_req = 0; d_req = 0; d_we = 0; d_be = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    busy = 0; owner = 0; starve = 0; sst = 0; gnt_lat = 0; rsp_lat = 1;
    spur_pct = 0; rnd_lat = 0; if_auto = 0; d_auto = 0; re_pct = 0;
    start_pct = 0; cyc_n = 0; last_if_rv = -1; last_d_rv = -1;
    ew = 0; ebe = 0; eaddr = 0; ewd = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_m_be", m_be, 4'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_rvalids", {if_rvalid, d_rvalid}, 2'b00);
`ifdef ARB_PERF_CNT_EN
    chk("rst_perf_conflict", perf_conflict_cnt, 32'h0);
    chk("rst_perf_busy", perf_busy_cnt, 32'h0);
`endif

    // Single fetch, immediate grant, response one cycle later.
    mem[32'h100] = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h100;
    start = cyc_n;
    for (k = 0; k < 20 && last_if_rv < start; k++) cyc();
    chk("fetch_latency", last_if_rv - start, 32'd2);
    cyc();

    // Contention: data load and fetch rise together.
    mem[32'h200] = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_wdata = 0;
    start = cyc_n;
    for (k = 0; k < 40 && (if_req || d_req || busy); k++) cyc();
    chk("contention_d_first", {31'd0, last_d_rv >= start && last_d_rv < last_if_rv}, 32'd1);
    chk("contention_done", {31'd0, if_req || d_req || busy}, 32'd0);

    // Starvation: back-to-back data, fetch always pending.
    wins.delete();
    if_auto = 1; d_auto = 1; re_pct = 100;
    new_if(); new_d();
    for (k = 0; k < 200 && wins.size() < 8; k++) cyc();
    chk("starve_wins", wins.size() >= 8, 1'b1);
    if (wins.size() >= 8)
      for (int i = 0; i < 8; i++) chk($sformatf("starve_win%0d", i), wins[i], (i % 4 == 3) ? 0 : 1);
    drain();

    // Store with slow memory and stray responses outside RESP.
    gnt_lat = 3; rsp_lat = 2; spur_pct = 50;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h300; d_wdata = 32'h1234;
    start = cyc_n;
    for (k = 0; k < 30 && last_d_rv < start; k++) cyc();
    chk("store_latency", last_d_rv - start, 32'd6);
    for (int i = 0; i < 4; i++) cyc();
    spur_pct = 0;

    // Reset while waiting for the response.
    gnt_lat = 0; rsp_lat = 4;
    if_req = 1'b1; if_addr = 32'h108;
    for (k = 0; k < 20 && sst != 2; k++) cyc();
    chk("reach_resp", sst, 2);
    reset = 1'b0; m_gnt = 0; m_rvalid = 0;
    @(posedge clk);
    #1;
    reset = 1'b1; if_req = 1'b0;
    busy = 0; sst = 0; starve = 0;
    chk("rst_mid_m_req", m_req, 1'b0);
    chk("rst_mid_rvalids", {if_rvalid, d_rvalid}, 2'b00);
    spur_pct = 100;
    cyc();   // late m_rvalid must not be forwarded
    spur_pct = 0;
    rsp_lat = 1;

`ifdef ARB_PERF_CNT_EN
    // Conflict counter: memory stalls grant so both requests stay high.
    gnt_lat = 20;
    new_if(); new_d();
    cyc(); cyc();
    c0 = perf_conflict_cnt; b0 = perf_busy_cnt;
    repeat (5) cyc();
    chk("perf_conflict_delta", perf_conflict_cnt - c0, 32'd5);
    chk("perf_busy_delta", perf_busy_cnt - b0, 32'd5);
    gnt_lat = 0;
    drain();
`else
    c0 = 0; b0 = 0;
`endif

    // Randomized traffic with random memory latency and stray responses.
    rnd_lat = 1; if_auto = 1; d_auto = 1; re_pct = 50; start_pct = 40; spur_pct = 20;
    repeat (800) cyc();
    spur_pct = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
